// File: rtl/airlock_pkg.sv
// Shared airlock definitions: FSM state encoding and default timing constants
// used by both the pressurization and evacuation controllers.
package airlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_ABORT  = 3'd4
  } state_e;

  localparam int FILL_TIMEOUT_DEF  = 16;
  localparam int SETTLE_CYCLES_DEF = 4;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pressurize_if.sv
// Sensor/request and valve/status signals between the airlock controller and
// the chamber plant.
interface pressurize_if;

  logic begin_Pressurization;
  logic InnerClosed;
  logic OuterClosed;
  logic Evacuated;
  logic Pressurized;
  logic Pressurize;
  logic Pressurization;
  logic Done;
  logic Fault;

  modport master (
    output begin_Pressurization, InnerClosed, OuterClosed, Evacuated, Pressurized,
    input  Pressurize, Pressurization, Done, Fault
  );

  modport slave (
    input  begin_Pressurization, InnerClosed, OuterClosed, Evacuated, Pressurized,
    output Pressurize, Pressurization, Done, Fault
  );

endinterface

// File: rtl/airlock_timer.sv
// Saturating cycle counter with synchronous clear, enable and a terminal-count
// compare against a caller-supplied value.
module airlock_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/pressurize.sv
// Airlock repressurization controller: Moore FSM that opens the fill valve,
// waits for pressure to settle, and aborts on door breach or fill timeout.
module pressurize
  import airlock_pkg::*;
#(
  parameter int FILL_TIMEOUT  = FILL_TIMEOUT_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic         Clock,
  input  logic         Reset,
  pressurize_if.slave  bus
);

  // Sized so the shared counter can reach either terminal value.
  localparam int CNT_W = $clog2(max_i(FILL_TIMEOUT, SETTLE_CYCLES)) + 1;

  state_e state, state_next;
  logic   doors_ok;
  logic   tmr_clr;
  logic   tmr_en;
  logic   tmr_tc;
  logic [CNT_W-1:0] tmr_tc_val;

  assign doors_ok = bus.InnerClosed & bus.OuterClosed;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.begin_Pressurization && bus.Evacuated && doors_ok)
          state_next = ST_FILL;
      end
      ST_FILL: begin
        if (!doors_ok)             state_next = ST_ABORT;
        else if (bus.Pressurized)  state_next = ST_SETTLE;
        else if (tmr_tc)           state_next = ST_ABORT;
      end
      ST_SETTLE: begin
        if (!doors_ok)             state_next = ST_ABORT;
        else if (!bus.Pressurized) state_next = ST_FILL;
        else if (tmr_tc)           state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_ABORT: begin
        if (!bus.begin_Pressurization) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Any state change restarts the count, so each FILL/SETTLE visit counts from 0.
  assign tmr_clr    = (state_next != state);
  assign tmr_en     = (state == ST_FILL) || (state == ST_SETTLE);
  assign tmr_tc_val = (state == ST_SETTLE) ? CNT_W'(SETTLE_CYCLES - 1)
                                           : CNT_W'(FILL_TIMEOUT - 1);

  airlock_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (Clock),
    .rst    (Reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .tc_val (tmr_tc_val),
    .tc     (tmr_tc)
  );

  always_comb begin
    bus.Pressurize     = 1'b0;
    bus.Pressurization = 1'b0;
    bus.Done           = 1'b0;
    bus.Fault          = 1'b0;
    case (state)
      ST_FILL: begin
        bus.Pressurize     = 1'b1;
        bus.Pressurization = 1'b1;
      end
      ST_SETTLE: bus.Pressurization = 1'b1;
      ST_DONE:   bus.Done           = 1'b1;
      ST_ABORT:  bus.Fault          = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: doc/pressurize.md
PRESSURIZE -- requirements
Module: pressurize

Interface
REQ-001 SHALL have parameter FILL_TIMEOUT, default 16, max cycles in FILL before fault.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, cycles held in SETTLE before completion.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port begin_Pressurization, input, 1, level request to repressurize the chamber.
REQ-006 SHALL have port InnerClosed, input, 1, inner door closed sensor.
REQ-007 SHALL have port OuterClosed, input, 1, outer door closed sensor.
REQ-008 SHALL have port Evacuated, input, 1, chamber-at-vacuum sensor.
REQ-009 SHALL have port Pressurized, input, 1, chamber-at-pressure sensor.
REQ-010 SHALL have port Pressurize, output, 1, fill valve open.
REQ-011 SHALL have port Pressurization, output, 1, cycle in progress (busy).
REQ-012 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port Fault, output, 1, aborted-cycle indication.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, FILL, SETTLE, DONE, ABORT; outputs decoded from state register only.
REQ-015 Output decode SHALL be: IDLE all 0; FILL Pressurize=1, Pressurization=1; SETTLE Pressurization=1; DONE Done=1; ABORT Fault=1.
REQ-016 IDLE -> FILL SHALL occur when begin_Pressurization=1, Evacuated=1, InnerClosed=1, OuterClosed=1 all sampled high; otherwise stay IDLE (request silently ignored).
REQ-017 FILL SHALL count cycles from 0; counter width $clog2(FILL_TIMEOUT)+1, no wrap.
REQ-018 FILL transition priority SHALL be: door open (either closed sensor low) -> ABORT; else Pressurized=1 -> SETTLE; else count==FILL_TIMEOUT-1 -> ABORT; else stay.
REQ-019 Entry into SETTLE SHALL clear the counter; Pressurize deasserts on the first SETTLE cycle.
REQ-020 SETTLE priority SHALL be: door open -> ABORT; else Pressurized=0 -> FILL (counter cleared, timeout restarts); else count==SETTLE_CYCLES-1 -> DONE.
REQ-021 DONE SHALL last exactly one cycle, then IDLE regardless of inputs.
REQ-022 ABORT SHALL hold Fault=1 until begin_Pressurization=0 is sampled, then IDLE.
REQ-023 A new cycle after DONE SHALL require begin_Pressurization and all IDLE-entry conditions again; a held request with Evacuated=0 does not restart.
REQ-024 begin_Pressurization dropping during FILL or SETTLE SHALL NOT abort the cycle.
REQ-025 Latency: request sampled at edge N -> Pressurize=1 after edge N; Pressurized sampled at edge M -> Done=1 after edge M+SETTLE_CYCLES.

Reset
REQ-026 Reset=1 SHALL immediately force state IDLE, counter 0, and Pressurize, Pressurization, Done, Fault all 0, independent of Clock.
REQ-027 Reset asserted mid-FILL SHALL close the valve without passing through ABORT; after release, FSM waits in IDLE for a fresh request.

Structure
REQ-028 State encoding typedef and default FILL_TIMEOUT/SETTLE_CYCLES constants SHALL live in shared package airlock_pkg, shared with the evacuation controller.
REQ-029 Cycle counter SHALL be sub-module airlock_timer (clear, enable, terminal-count compare, async reset), reusable by the evacuation side.

Verification
REQ-030 Nominal: doors closed, Evacuated=1, request at cycle 2, Pressurized=1 at cycle 6 -> Pressurize high cycles 3-6, Done pulse at cycle 11 (SETTLE_CYCLES=4), then IDLE.
REQ-031 Timeout: Pressurized held 0 -> Pressurize high exactly 16 cycles, then Fault=1 until request drops, then all outputs 0.
REQ-032 Door breach: OuterClosed=0 at FILL cycle 3 with Pressurized=1 same cycle -> ABORT (door wins), Pressurize=0 next cycle.
REQ-033 Pressure loss: Pressurized drops in SETTLE cycle 2 -> back to FILL, Pressurize=1, timeout restarts at 0.
REQ-034 Precondition: request with InnerClosed=0 or Evacuated=0 -> outputs stay 0 for 20 cycles.
REQ-035 Async reset: Reset pulsed between edges during FILL -> Pressurize and Pressurization 0 before next edge; no Fault.
